manual_override_ctrl: RTL and testbench
=======================================

MANUAL_OVERRIDE_CTRL -- requirements
Module: manual_override_ctrl

Interface
REQ-001 Parameter NCHAN, default 2, number of independent motor channels (1..8).
REQ-002 Parameter VAL_W, default 8, width of each channel's magnitude output.
REQ-003 Parameter STEPSIZE, default 2, magnitude issued for a single step.
REQ-004 Parameter GO_MIN, default 1, starting magnitude of continuous motion.
REQ-005 Parameter GO_MAX, default 16, saturation magnitude of continuous motion.
REQ-006 Parameter RAMP_DIV, default 1024, clock cycles per ramp increment (>=1).
REQ-007 clock  in  1  sole clock, all state on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-009 cmd_valid  in  1  command strobe; command/chan sampled on each rising edge where high.
REQ-010 command  in  4  opcode: 1000 step left, 1001 step right, 1010 go, 1011 stop, 1111 stop-all; all others ignored.
REQ-011 chan  in  CH_W  target channel index, CH_W = max(1, clog2(NCHAN)).
REQ-012 ready  in  NCHAN  per-channel downstream accept of a pending step.
REQ-013 dir  out  NCHAN  per-channel direction, 0 = left, 1 = right.
REQ-014 val  out  NCHAN*VAL_W  per-channel magnitude, channel i at bits [i*VAL_W +: VAL_W].
REQ-015 done  out  NCHAN  per-channel output-valid.
REQ-016 busy  out  NCHAN  per-channel high while in GO state.
REQ-017 com_debug  out  4  last accepted (recognised, in-range) opcode.

Function
REQ-018 Sampled command/chan SHALL be registered; resulting output change SHALL appear on the following rising edge (2 edges from strobe to outputs).
REQ-019 Commands with chan >= NCHAN or unrecognised opcode SHALL be dropped with no state or com_debug change.
REQ-020 Each channel SHALL run an FSM with states IDLE, STEP, GO; outputs of channel i depend only on commands addressed to i, plus stop-all.
REQ-021 IDLE: done=0, val=0, busy=0, dir holds last value.
REQ-022 IDLE + step left/right: -> STEP, dir=0/1, val=STEPSIZE, done=1.
REQ-023 STEP: done and val SHALL hold until ready[i] is sampled high, then next edge -> IDLE (done=0, val=0); minimum done width is one cycle even if ready already high.
REQ-024 STEP + new step: ignored (no queueing); STEP + go: ignored until step completes.
REQ-025 IDLE + go: -> GO, val=GO_MIN, done=1, busy=1, dir unchanged, ramp counter cleared.
REQ-026 GO: done=1 regardless of ready; every RAMP_DIV cycles val increments by 1, saturating at GO_MAX, never wrapping.
REQ-027 GO + step or go: ignored; ramp continues uninterrupted.
REQ-028 stop (any state): -> IDLE next edge, val=0, done=0, busy=0, ramp counter cleared, dir retained.
REQ-029 stop-all (chan ignored): applies REQ-028 to every channel on the same edge.
REQ-030 Elaboration SHALL fail if GO_MIN > GO_MAX, GO_MAX >= 2^VAL_W, or STEPSIZE >= 2^VAL_W.
REQ-031 Ramp counter SHALL be ceil(log2(RAMP_DIV+1)) bits, per channel, wrapping to 0 on each increment.

Reset
REQ-032 On reset high, asynchronously: all FSMs IDLE, dir=0, val=0, done=0, busy=0, com_debug=0, ramp counters 0, pending command register cleared.
REQ-033 A command strobed in the same cycle reset deasserts SHALL be ignored; reset mid-STEP or mid-GO drops the motion with no further done.

Verification
REQ-034 Step right ch1, ready[1]=0 for 5 cycles then 1 -> dir[1]=1, val ch1=2, done[1] high 2 edges after strobe, falls one edge after ready sampled; ch0 stays 0.
REQ-035 Go ch0, RAMP_DIV=4, GO_MAX=3 -> val ch0 1,2,3 at 4-cycle spacing then holds 3; busy[0]=1, done[0]=1 throughout.
REQ-036 Go ch0 and ch1, then stop-all -> both val=0, done=0, busy=0 on same edge; dir retained.
REQ-037 Step left ch0 while in GO, and chan=3 with NCHAN=2 -> no output or com_debug change.
REQ-038 Assert reset mid-GO asynchronously -> all outputs 0 before next clock edge; after release, IDLE until new command.

Source files
------------

// File: rtl/manual_override_ctrl.sv
// Manual motor override controller: per-channel step / continuous-go FSMs.
// Ports: clock, reset (async high); cmd_valid, command[3:0], chan select a
// channel command; ready[i] accepts a pending step; outputs dir, val
// (channel i at [i*VAL_W +: VAL_W]), done, busy per channel; com_debug.
module manual_override_ctrl #(
    parameter int NCHAN    = 2,
    parameter int VAL_W    = 8,
    parameter int STEPSIZE = 2,
    parameter int GO_MIN   = 1,
    parameter int GO_MAX   = 16,
    parameter int RAMP_DIV = 1024,
    localparam int CH_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [3:0]             command,
    input  logic [CH_W-1:0]        chan,
    input  logic [NCHAN-1:0]       ready,
    output logic [NCHAN-1:0]       dir,
    output logic [NCHAN*VAL_W-1:0] val,
    output logic [NCHAN-1:0]       done,
    output logic [NCHAN-1:0]       busy,
    output logic [3:0]             com_debug
);

    localparam int RC_W = $clog2(RAMP_DIV + 1);

    localparam logic [3:0] OP_LEFT  = 4'b1000;
    localparam logic [3:0] OP_RIGHT = 4'b1001;
    localparam logic [3:0] OP_GO    = 4'b1010;
    localparam logic [3:0] OP_STOP  = 4'b1011;
    localparam logic [3:0] OP_ALL   = 4'b1111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_GO   = 2'd2;

    if (GO_MIN > GO_MAX) begin : g_err_min
        $error("GO_MIN must not exceed GO_MAX");
    end
    if (GO_MAX >= (2 ** VAL_W)) begin : g_err_max
        $error("GO_MAX does not fit in VAL_W bits");
    end
    if (STEPSIZE >= (2 ** VAL_W)) begin : g_err_step
        $error("STEPSIZE does not fit in VAL_W bits");
    end
    if (NCHAN < 1 || NCHAN > 8) begin : g_err_nchan
        $error("NCHAN must be 1..8");
    end
    if (RAMP_DIV < 1) begin : g_err_div
        $error("RAMP_DIV must be at least 1");
    end

    // armed stays low for the first edge after reset release so a strobe
    // coinciding with the release is never captured.
    logic            armed;
    logic            pend_v;
    logic [3:0]      pend_op;
    logic [CH_W-1:0] pend_ch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed   <= 1'b0;
            pend_v  <= 1'b0;
            pend_op <= 4'd0;
            pend_ch <= '0;
        end else begin
            armed   <= 1'b1;
            pend_v  <= cmd_valid & armed;
            pend_op <= command;
            pend_ch <= chan;
        end
    end

    logic op_known;
    logic op_all;
    logic ch_ok;
    logic accept;

    always_comb begin
        op_known = pend_op inside {OP_LEFT, OP_RIGHT, OP_GO, OP_STOP, OP_ALL};
        op_all   = (pend_op == OP_ALL);
        ch_ok    = ({1'b0, pend_ch} < (CH_W + 1)'(NCHAN));
        // stop-all ignores chan, so it is accepted even when chan is out of range
        accept   = pend_v & op_known & (op_all | ch_ok);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            com_debug <= 4'd0;
        end else if (accept) begin
            com_debug <= pend_op;
        end
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_ch
        logic [1:0]       state;
        logic [VAL_W-1:0] mag;
        logic [RC_W-1:0]  ramp;
        logic             d;
        logic             hit;
        logic             stop_hit;

        assign hit      = accept & (op_all | (pend_ch == CH_W'(i)));
        assign stop_hit = hit & ((pend_op == OP_STOP) | op_all);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state <= S_IDLE;
                mag   <= '0;
                ramp  <= '0;
                d     <= 1'b0;
            end else if (stop_hit) begin
                state <= S_IDLE;
                mag   <= '0;
                ramp  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (hit && (pend_op == OP_LEFT || pend_op == OP_RIGHT)) begin
                            state <= S_STEP;
                            d     <= pend_op[0];
                            mag   <= VAL_W'(STEPSIZE);
                        end else if (hit && pend_op == OP_GO) begin
                            state <= S_GO;
                            mag   <= VAL_W'(GO_MIN);
                            ramp  <= '0;
                        end
                    end
                    S_STEP: begin
                        // entry edge already raised done, so done lasts >= 1 cycle
                        if (ready[i]) begin
                            state <= S_IDLE;
                            mag   <= '0;
                        end
                    end
                    S_GO: begin
                        if (ramp == RC_W'(RAMP_DIV - 1)) begin
                            ramp <= '0;
                            if (mag < VAL_W'(GO_MAX)) begin
                                mag <= mag + VAL_W'(1);
                            end
                        end else begin
                            ramp <= ramp + RC_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        mag   <= '0;
                        ramp  <= '0;
                    end
                endcase
            end
        end

        assign dir[i]                 = d;
        assign val[i*VAL_W +: VAL_W]  = mag;
        assign done[i]                = (state != S_IDLE);
        assign busy[i]                = (state == S_GO);
    end

endmodule

// File: tb/tb_manual_override_ctrl.sv
// Directed bench for manual_override_ctrl (3 channels, fast ramp).
// Drives and samples on falling edges; expected values are hand-derived.
module tb_manual_override_ctrl;

    localparam logic [3:0] OP_LEFT  = 4'b1000;
    localparam logic [3:0] OP_RIGHT = 4'b1001;
    localparam logic [3:0] OP_GO    = 4'b1010;
    localparam logic [3:0] OP_STOP  = 4'b1011;
    localparam logic [3:0] OP_ALL   = 4'b1111;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  command;
    logic [1:0]  chan;
    logic [2:0]  ready;
    logic [2:0]  dir;
    logic [23:0] val;
    logic [2:0]  done;
    logic [2:0]  busy;
    logic [3:0]  com_debug;

    int n_checks;
    int n_pass;

    manual_override_ctrl #(
        .NCHAN(3), .VAL_W(8), .STEPSIZE(2), .GO_MIN(1),
        .GO_MAX(3), .RAMP_DIV(4)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid),
        .command(command), .chan(chan), .ready(ready), .dir(dir),
        .val(val), .done(done), .busy(busy), .com_debug(com_debug)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called at a falling edge; returns at the falling edge after the
    // second rising edge, when the command's effect is visible.
    task automatic send(input logic [3:0] op, input logic [1:0] ch);
        cmd_valid = 1'b1;
        command   = op;
        chan      = ch;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_checks++; if (dir !== 3'b000) $display("FAIL rst_dir got %b exp 000", dir); else n_pass++;
        n_checks++; if (val !== 24'h0) $display("FAIL rst_val got %h exp 000000", val); else n_pass++;
        n_checks++; if (done !== 3'b000) $display("FAIL rst_done got %b exp 000", done); else n_pass++;
        n_checks++; if (busy !== 3'b000) $display("FAIL rst_busy got %b exp 000", busy); else n_pass++;
        n_checks++; if (com_debug !== 4'h0) $display("FAIL rst_com got %h exp 0", com_debug); else n_pass++;
        @(negedge clock);
        @(negedge clock);
        // strobe in the cycle reset is released must be dropped
        reset     = 1'b0;
        cmd_valid = 1'b1;
        command   = OP_GO;
        chan      = 2'd0;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (busy !== 3'b000) $display("FAIL rel_busy got %b exp 000", busy); else n_pass++;
        n_checks++; if (com_debug !== 4'h0) $display("FAIL rel_com got %h exp 0", com_debug); else n_pass++;
    endtask

    task automatic test_step();
        ready     = 3'b000;
        cmd_valid = 1'b1;
        command   = OP_RIGHT;
        chan      = 2'd1;
        @(negedge clock);
        cmd_valid = 1'b0;
        n_checks++; if (done !== 3'b000) $display("FAIL step_e1_done got %b exp 000", done); else n_pass++;
        @(negedge clock);
        n_checks++; if (done !== 3'b010) $display("FAIL step_done got %b exp 010", done); else n_pass++;
        n_checks++; if (dir !== 3'b010) $display("FAIL step_dir got %b exp 010", dir); else n_pass++;
        n_checks++; if (val[15:8] !== 8'd2) $display("FAIL step_val1 got %0d exp 2", val[15:8]); else n_pass++;
        n_checks++; if (val[7:0] !== 8'd0) $display("FAIL step_val0 got %0d exp 0", val[7:0]); else n_pass++;
        n_checks++; if (com_debug !== OP_RIGHT) $display("FAIL step_com got %h exp 9", com_debug); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++; if (done !== 3'b010) $display("FAIL step_hold%0d got %b exp 010", k, done); else n_pass++;
        end
        ready = 3'b010;
        @(negedge clock);
        ready = 3'b000;
        n_checks++; if (done !== 3'b000) $display("FAIL step_fall got %b exp 000", done); else n_pass++;
        n_checks++; if (val !== 24'h0) $display("FAIL step_val_idle got %h exp 000000", val); else n_pass++;
        n_checks++; if (dir !== 3'b010) $display("FAIL step_dir_keep got %b exp 010", dir); else n_pass++;
        // ready already high: done still lasts exactly one cycle
        ready = 3'b111;
        send(OP_LEFT, 2'd2);
        n_checks++; if (done !== 3'b100) $display("FAIL rdy_done got %b exp 100", done); else n_pass++;
        n_checks++; if (val[23:16] !== 8'd2) $display("FAIL rdy_val2 got %0d exp 2", val[23:16]); else n_pass++;
        @(negedge clock);
        ready = 3'b000;
        n_checks++; if (done !== 3'b000) $display("FAIL rdy_fall got %b exp 000", done); else n_pass++;
    endtask

    task automatic test_step_ignored();
        send(OP_LEFT, 2'd0);
        send(OP_RIGHT, 2'd0);
        n_checks++; if (dir !== 3'b010) $display("FAIL ign_dir got %b exp 010", dir); else n_pass++;
        n_checks++; if (val[7:0] !== 8'd2) $display("FAIL ign_val got %0d exp 2", val[7:0]); else n_pass++;
        send(OP_GO, 2'd0);
        n_checks++; if (busy !== 3'b000) $display("FAIL ign_go got %b exp 000", busy); else n_pass++;
        n_checks++; if (done !== 3'b001) $display("FAIL ign_done got %b exp 001", done); else n_pass++;
        ready = 3'b001;
        @(negedge clock);
        ready = 3'b000;
        n_checks++; if (done !== 3'b000) $display("FAIL ign_fall got %b exp 000", done); else n_pass++;
    endtask

    task automatic test_go_ramp();
        logic [7:0] exp_v;
        send(OP_GO, 2'd0);
        n_checks++; if (val[7:0] !== 8'd1) $display("FAIL go_start got %0d exp 1", val[7:0]); else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            exp_v = (k >= 8) ? 8'd3 : 8'(1 + k / 4);
            n_checks++; if (val[7:0] !== exp_v) $display("FAIL go_val%0d got %0d exp %0d", k, val[7:0], exp_v); else n_pass++;
            n_checks++; if (busy !== 3'b001 || done !== 3'b001) $display("FAIL go_flags%0d got %b/%b exp 001/001", k, busy, done); else n_pass++;
        end
        send(OP_LEFT, 2'd0);
        n_checks++; if (val[7:0] !== 8'd3) $display("FAIL go_step_val got %0d exp 3", val[7:0]); else n_pass++;
        n_checks++; if (busy !== 3'b001) $display("FAIL go_step_busy got %b exp 001", busy); else n_pass++;
        n_checks++; if (dir !== 3'b010) $display("FAIL go_step_dir got %b exp 010", dir); else n_pass++;
        send(OP_GO, 2'd3);
        n_checks++; if (com_debug !== OP_LEFT) $display("FAIL oor_com got %h exp 8", com_debug); else n_pass++;
        n_checks++; if (busy !== 3'b001) $display("FAIL oor_busy got %b exp 001", busy); else n_pass++;
        send(4'b0101, 2'd1);
        n_checks++; if (com_debug !== OP_LEFT) $display("FAIL bad_op_com got %h exp 8", com_debug); else n_pass++;
        n_checks++; if (busy !== 3'b001) $display("FAIL bad_op_busy got %b exp 001", busy); else n_pass++;
    endtask

    task automatic test_stop();
        send(OP_GO, 2'd1);
        send(OP_GO, 2'd2);
        n_checks++; if (busy !== 3'b111) $display("FAIL stop_pre got %b exp 111", busy); else n_pass++;
        send(OP_STOP, 2'd2);
        n_checks++; if (busy !== 3'b011) $display("FAIL stop_one got %b exp 011", busy); else n_pass++;
        n_checks++; if (val[23:16] !== 8'd0) $display("FAIL stop_val2 got %0d exp 0", val[23:16]); else n_pass++;
        send(OP_ALL, 2'd3);
        n_checks++; if (busy !== 3'b000) $display("FAIL all_busy got %b exp 000", busy); else n_pass++;
        n_checks++; if (done !== 3'b000) $display("FAIL all_done got %b exp 000", done); else n_pass++;
        n_checks++; if (val !== 24'h0) $display("FAIL all_val got %h exp 000000", val); else n_pass++;
        n_checks++; if (dir !== 3'b010) $display("FAIL all_dir got %b exp 010", dir); else n_pass++;
        n_checks++; if (com_debug !== OP_ALL) $display("FAIL all_com got %h exp f", com_debug); else n_pass++;
    endtask

    task automatic test_reset_mid_go();
        send(OP_GO, 2'd1);
        n_checks++; if (busy !== 3'b010) $display("FAIL mid_pre got %b exp 010", busy); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 3'b000 || done !== 3'b000) $display("FAIL mid_flags got %b/%b exp 000/000", busy, done); else n_pass++;
        n_checks++; if (val !== 24'h0) $display("FAIL mid_val got %h exp 000000", val); else n_pass++;
        n_checks++; if (dir !== 3'b000) $display("FAIL mid_dir got %b exp 000", dir); else n_pass++;
        n_checks++; if (com_debug !== 4'h0) $display("FAIL mid_com got %h exp 0", com_debug); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++; if (done !== 3'b000 || busy !== 3'b000) $display("FAIL post_rst%0d got %b/%b exp 000/000", k, done, busy); else n_pass++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        command   = 4'd0;
        chan      = 2'd0;
        ready     = 3'b000;
        test_reset();
        test_step();
        test_step_ignored();
        test_go_ramp();
        test_stop();
        test_reset_mid_go();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
